decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter DWIDTH, 32, instruction and immediate width in bits.
REQ-002 Parameter AWIDTH, 32, program-counter width in bits.
REQ-003 Parameter CNT_W, 16, width of the decoded-instruction counter.
REQ-004 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 flush_i  in  1  discard all buffered instructions.
REQ-007 in_valid_i / in_ready_o  in/out  1/1  upstream handshake.
REQ-008 pc_i / insn_i  in  AWIDTH/DWIDTH  fetched PC and instruction.
REQ-009 out_valid_o / out_ready_i  out/in  1/1  downstream handshake.
REQ-010 pc_o, insn_o  out  AWIDTH, DWIDTH  PC and raw instruction of the head entry.
REQ-011 opcode_o[6:0], rd_o[4:0], rs1_o[4:0], rs2_o[4:0], funct7_o[6:0], funct3_o[2:0], shamt_o[4:0]  out  fields of insn_o.
REQ-012 imm_o  out  DWIDTH  sign-extended immediate of insn_o.
REQ-013 illegal_o  out  1  head opcode is not RV32I.
REQ-014 dec_count_o  out  CNT_W  count of output handshakes.

Function
REQ-015 The block SHALL be a 2-entry pipeline register: a main entry drives the outputs, and a skid entry is behind it.
REQ-016 in_ready_o SHALL equal NOT skid_valid, with no combinational path from out_ready_i.
REQ-017 Input fire (in_valid_i & in_ready_o) SHALL write the main entry if it is empty or draining this cycle, and the skid entry otherwise.
REQ-018 Output fire (out_valid_o & out_ready_i) SHALL move the skid entry into main, or empty main if skid is empty.
REQ-019 Latency SHALL be 1 cycle from input fire to out_valid_o when the buffer is empty.
REQ-020 Throughput SHALL be one instruction per cycle with out_ready_i held high.
REQ-021 Ordering SHALL be strictly FIFO.
REQ-022 Field outputs SHALL be combinational slices of insn_o: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 and shamt [24:20], funct7 [31:25].
REQ-023 imm_o SHALL be selected by opcode as follows:
- I-type (0000011, 0010011, 1100111, 1110011): sext insn[31:20].
- S-type (0100011): sext {[31:25],[11:7]}.
- B-type (1100011): sext {[31],[7],[30:25],[11:8],0}.
- U-type (0110111, 0010111): {[31:12],12'b0}.
- J-type (1101111): sext {[31],[19:12],[20],[30:21],0}.
- Any other opcode: 0.
REQ-024 out_valid_o low SHALL NOT change pc_o or insn_o; they hold their last value.
REQ-025 flush_i SHALL clear both valid bits next cycle and SHALL win over a simultaneous input fire, which is discarded; pc/insn data regs are unchanged.
REQ-026 dec_count_o SHALL increment by 1 per output fire and wrap from 2^CNT_W-1 to 0; an output fire coincident with flush_i still counts.
REQ-027 Input fire and output fire with both entries full SHALL NOT occur, because in_ready_o is low.

Reset
REQ-028 While rst is high, the block SHALL clear both valid bits and set pc_o, insn_o and dec_count_o to 0.
REQ-029 Reset values of the derived outputs SHALL be: out_valid_o=0, in_ready_o=1, opcode_o=0, imm_o=0, illegal_o=0 in both configurations.
REQ-030 rst SHALL override flush_i and any handshake, and reset mid-stream SHALL drop buffered instructions.

Configuration
REQ-031 With DECODE_ILLEGAL_CHK_EN defined, illegal_o SHALL be 1 when out_valid_o is high and opcode_o is not one of: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111, 1110011.
REQ-032 With DECODE_ILLEGAL_CHK_EN undefined, illegal_o SHALL be tied to 0 and no check logic SHALL be built.

Verification
REQ-033 The bench SHALL drive pc_i=0x01000000 and insn_i=0x00500093 with out_ready_i=1 -> next cycle out_valid_o=1, opcode_o=0x13, rd_o=1, rs1_o=0, imm_o=0x00000005.
REQ-034 The bench SHALL drive insn_i=0xFE112E23 (sw x1,-4(x2)) -> imm_o=0xFFFFFFFC, rs1_o=2, rs2_o=1, funct3_o=2.
REQ-035 The bench SHALL hold out_ready_i=0 and offer A, B, C -> A in main, B in skid, in_ready_o=0, C held; release -> A, B, C emitted in order and dec_count_o=3.
REQ-036 The bench SHALL assert flush_i with both entries full and in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, offered beat not emitted.
REQ-037 The bench SHALL pass insn_i=0x00000000 -> illegal_o=1 with DECODE_ILLEGAL_CHK_EN and illegal_o=0 without it.
REQ-038 The bench SHALL use CNT_W=4 with 17 output fires -> dec_count_o=1, then pulse rst -> dec_count_o=0, out_valid_o=0.

Source files
------------

// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pipe
//  Function : Two-entry (main + skid) RV32I instruction pipeline register that
//             decodes the instruction fields and immediate of its head entry.
//             Define DECODE_ILLEGAL_CHK_EN to build the illegal-opcode check.
//  Revision : 1.0  initial release
// ============================================================================
module decode_pipe #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] insn_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [6:0]        funct7_o,
    output logic [2:0]        funct3_o,
    output logic [4:0]        shamt_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  dec_count_o
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    logic              r_main_valid;
    logic              r_skid_valid;
    logic [AWIDTH-1:0] r_main_pc;
    logic [DWIDTH-1:0] r_main_insn;
    logic [AWIDTH-1:0] r_skid_pc;
    logic [DWIDTH-1:0] r_skid_insn;
    logic [CNT_W-1:0]  r_count;

    logic              w_in_fire;
    logic              w_out_fire;
    logic [DWIDTH-1:0] w_imm;
    logic              w_sign;

    // Ready depends only on registered state, never on out_ready_i.
    assign in_ready_o = ~r_skid_valid;
    assign w_in_fire  = in_valid_i & ~r_skid_valid;
    assign w_out_fire = r_main_valid & out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_pc    <= '0;
            r_main_insn  <= '0;
            r_skid_pc    <= '0;
            r_skid_insn  <= '0;
            r_count      <= '0;
        end else begin
            if (w_out_fire) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (flush_i) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_out_fire && r_skid_valid) begin
                // Skid full implies no input fire this cycle.
                r_main_pc    <= r_skid_pc;
                r_main_insn  <= r_skid_insn;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire && (!r_main_valid || w_out_fire)) begin
                r_main_pc    <= pc_i;
                r_main_insn  <= insn_i;
                r_main_valid <= 1'b1;
            end else if (w_in_fire) begin
                r_skid_pc    <= pc_i;
                r_skid_insn  <= insn_i;
                r_skid_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_main_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_main_valid;
    assign pc_o        = r_main_pc;
    assign insn_o      = r_main_insn;
    assign dec_count_o = r_count;

    assign opcode_o = r_main_insn[6:0];
    assign rd_o     = r_main_insn[11:7];
    assign funct3_o = r_main_insn[14:12];
    assign rs1_o    = r_main_insn[19:15];
    assign rs2_o    = r_main_insn[24:20];
    assign shamt_o  = r_main_insn[24:20];
    assign funct7_o = r_main_insn[31:25];

    assign w_sign = r_main_insn[31];

    always_comb begin
        w_imm = '0;
        case (r_main_insn[6:0])
            c_OP_LOAD, c_OP_IMM, c_OP_JALR, c_OP_SYSTEM:
                w_imm = {{(DWIDTH-11){w_sign}}, r_main_insn[30:20]};
            c_OP_STORE:
                w_imm = {{(DWIDTH-11){w_sign}}, r_main_insn[30:25], r_main_insn[11:7]};
            c_OP_BRANCH:
                w_imm = {{(DWIDTH-12){w_sign}}, r_main_insn[7], r_main_insn[30:25],
                         r_main_insn[11:8], 1'b0};
            c_OP_LUI, c_OP_AUIPC:
                w_imm = {{(DWIDTH-31){w_sign}}, r_main_insn[30:12], 12'b0};
            c_OP_JAL:
                w_imm = {{(DWIDTH-20){w_sign}}, r_main_insn[19:12], r_main_insn[20],
                         r_main_insn[30:21], 1'b0};
            default:
                w_imm = '0;
        endcase
    end

    assign imm_o = w_imm;

`ifdef DECODE_ILLEGAL_CHK_EN
    logic w_legal;

    always_comb begin
        w_legal = 1'b0;
        case (r_main_insn[6:0])
            7'b0110011, c_OP_IMM, c_OP_LOAD, c_OP_STORE, c_OP_BRANCH, c_OP_JAL,
            c_OP_JALR, c_OP_LUI, c_OP_AUIPC, 7'b0001111, c_OP_SYSTEM:
                w_legal = 1'b1;
            default:
                w_legal = 1'b0;
        endcase
    end

    assign illegal_o = r_main_valid & ~w_legal;
`else
    assign illegal_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_pipe
//  Function : Self-checking bench for decode_pipe: queue-based reference model
//             compared every cycle, plus directed literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] pc_i;
    logic [31:0] insn_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o, rs1_o, rs2_o, shamt_o;
    logic [6:0]  funct7_o;
    logic [2:0]  funct3_o;
    logic [31:0] imm_o;
    logic        illegal_o;
    logic [3:0]  dec_count_o;

    int n_cmp  = 0;
    int n_fail = 0;

    decode_pipe #(.DWIDTH(32), .AWIDTH(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .insn_i(insn_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pc_o(pc_o), .insn_o(insn_o),
        .opcode_o(opcode_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .funct7_o(funct7_o), .funct3_o(funct3_o), .shamt_o(shamt_o),
        .imm_o(imm_o), .illegal_o(illegal_o), .dec_count_o(dec_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediate derived with signed arithmetic shifts rather than bit replication.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [31:0] s;
        s = 32'($signed(i) >>> 31);
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                return 32'($signed(i) >>> 20);
            7'b0100011:
                return (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
            7'b1100011:
                return (s << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            7'b0110111, 7'b0010111:
                return i & 32'hFFFF_F000;
            7'b1101111:
                return (s << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            default:
                return 32'h0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic valid, input logic [6:0] op);
`ifdef DECODE_ILLEGAL_CHK_EN
        logic [6:0] legal [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                   7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
        if (!valid) return 1'b0;
        foreach (legal[k]) if (legal[k] == op) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: FIFO of {pc,insn} holding at most two entries.
    logic [63:0] q[$];
    logic [3:0]  m_cnt   = '0;
    logic [63:0] m_last  = '0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        bit in_f, out_f;
        started = 1'b1;
        if (rst) begin
            q.delete();
            m_cnt  = '0;
            m_last = '0;
        end else begin
            in_f  = in_valid_i && (q.size() < 2);
            out_f = (q.size() > 0) && out_ready_i;
            if (out_f) begin
                m_cnt++;
                void'(q.pop_front());
            end
            if (flush_i) q.delete();
            else if (in_f) q.push_back({pc_i, insn_i});
            if (q.size() > 0) m_last = q[0];
        end
    end

    always @(negedge clk) begin
        logic [31:0] mi;
        if (started) begin
            mi = m_last[31:0];
            chk("out_valid", 32'(out_valid_o), 32'(q.size() > 0));
            chk("in_ready",  32'(in_ready_o),  32'(q.size() < 2));
            chk("pc",        pc_o,   m_last[63:32]);
            chk("insn",      insn_o, mi);
            chk("opcode",    32'(opcode_o), 32'(mi & 32'h7F));
            chk("rd",        32'(rd_o),     (mi >> 7) & 32'h1F);
            chk("funct3",    32'(funct3_o), (mi >> 12) & 32'h7);
            chk("rs1",       32'(rs1_o),    (mi >> 15) & 32'h1F);
            chk("rs2",       32'(rs2_o),    (mi >> 20) & 32'h1F);
            chk("shamt",     32'(shamt_o),  (mi >> 20) & 32'h1F);
            chk("funct7",    32'(funct7_o), mi >> 25);
            chk("imm",       imm_o, ref_imm(mi));
            chk("illegal",   32'(illegal_o), 32'(ref_illegal(q.size() > 0, mi[6:0])));
            chk("count",     32'(dec_count_o), 32'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h00};
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 11)];
        return r;
    endfunction

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        pc_i = '0; insn_i = '0;
        repeat (3) cyc();
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_in_ready",  32'(in_ready_o),  32'd1);
        chk("rst_opcode",    32'(opcode_o),    32'd0);
        chk("rst_imm",       imm_o,            32'd0);
        chk("rst_illegal",   32'(illegal_o),   32'd0);
        chk("rst_pc",        pc_o,             32'd0);
        chk("rst_count",     32'(dec_count_o), 32'd0);
        rst = 1'b0;

        // addi x1,x0,5
        in_valid_i = 1'b1; out_ready_i = 1'b1; pc_i = 32'h0100_0000; insn_i = 32'h0050_0093;
        cyc();
        in_valid_i = 1'b0;
        chk("addi_valid",  32'(out_valid_o), 32'd1);
        chk("addi_opcode", 32'(opcode_o),    32'h13);
        chk("addi_rd",     32'(rd_o),        32'd1);
        chk("addi_rs1",    32'(rs1_o),       32'd0);
        chk("addi_imm",    imm_o,            32'h0000_0005);

        // sw x1,-4(x2)
        in_valid_i = 1'b1; pc_i = 32'h0100_0004; insn_i = 32'hFE11_2E23;
        cyc();
        in_valid_i = 1'b0;
        chk("sw_imm",    imm_o,            32'hFFFF_FFFC);
        chk("sw_rs1",    32'(rs1_o),       32'd2);
        chk("sw_rs2",    32'(rs2_o),       32'd1);
        chk("sw_funct3", 32'(funct3_o),    32'd2);

        in_valid_i = 1'b1; pc_i = 32'h0100_0008; insn_i = 32'h0000_0000;
        cyc();
        in_valid_i = 1'b0;
`ifdef DECODE_ILLEGAL_CHK_EN
        chk("zero_illegal", 32'(illegal_o), 32'd1);
`else
        chk("zero_illegal", 32'(illegal_o), 32'd0);
`endif
        cyc();

        // Back-pressure: A in main, B in skid, C held off.
        rst = 1'b1; cyc(); rst = 1'b0;
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        pc_i = 32'hA; insn_i = 32'h0000_0013; cyc();
        pc_i = 32'hB; insn_i = 32'h0000_0033; cyc();
        pc_i = 32'hC; insn_i = 32'h0000_0037; cyc();
        chk("bp_in_ready", 32'(in_ready_o), 32'd0);
        chk("bp_head_A",   pc_o,            32'hA);
        out_ready_i = 1'b1; cyc();
        chk("bp_head_B",   pc_o,            32'hB);
        chk("bp_ready_B",  32'(in_ready_o), 32'd1);
        cyc();
        in_valid_i = 1'b0;
        chk("bp_head_C",   pc_o,            32'hC);
        cyc();
        chk("bp_drained",  32'(out_valid_o), 32'd0);
        chk("bp_count",    32'(dec_count_o), 32'd3);

        // Flush with both entries full and a beat offered.
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        pc_i = 32'h10; cyc();
        pc_i = 32'h14; cyc();
        pc_i = 32'hD0; flush_i = 1'b1; cyc();
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("fl_out_valid", 32'(out_valid_o), 32'd0);
        chk("fl_in_ready",  32'(in_ready_o),  32'd1);
        out_ready_i = 1'b1; cyc(); cyc();
        chk("fl_no_emit",   32'(out_valid_o), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 499) == 0);
            flush_i     = ($urandom_range(0, 39) == 0);
            in_valid_i  = ($urandom_range(0, 9) < 7);
            out_ready_i = ($urandom_range(0, 9) < 7);
            pc_i        = $urandom;
            insn_i      = rand_insn();
            cyc();
        end

        // Counter wrap: 17 output fires on a 4-bit counter.
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; cyc(); rst = 1'b0;
        out_ready_i = 1'b1; in_valid_i = 1'b1;
        for (int n = 0; n < 17; n++) begin
            pc_i = 32'h100 + 32'(n) * 4; insn_i = rand_insn();
            cyc();
        end
        in_valid_i = 1'b0;
        cyc(); cyc();
        chk("wrap_count", 32'(dec_count_o), 32'd1);
        rst = 1'b1; cyc();
        chk("wrap_rst_count", 32'(dec_count_o), 32'd0);
        chk("wrap_rst_valid", 32'(out_valid_o), 32'd0);
        rst = 1'b0; cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
